// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC, request/response fetch from instruction memory, one-entry skid buffer and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch and stall performance counters.
module instr_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus4,
  output logic [2:0]        id_opcode,
  output logic [1:0]        id_dir_mode,
  output logic [1:0]        id_inst_type
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {REQ, WAIT, SKID} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              drop;
  logic [31:0]       skid_instr;
  logic [ADDR_W-1:0] skid_pc;

  logic path_clear;
  logic rsp;
  logic load_mem;
  logic park;
  logic load_skid;
  logic accept;

  assign path_clear = !(id_valid && stall);
  assign rsp        = (state == WAIT) && imem_rvalid;
  assign load_mem   = rsp && !drop && path_clear && !redirect;
  assign park       = rsp && !drop && !path_clear && !redirect;
  assign load_skid  = (state == SKID) && !stall && !redirect;
  assign accept     = imem_req && imem_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= REQ;
    else     state <= state_next;
  end

  // Redirect outranks everything; a response landing in the redirect cycle completes the old request.
  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = (state == WAIT && !imem_rvalid) ? WAIT : REQ;
    end else begin
      unique case (state)
        REQ:  if (accept) state_next = WAIT;
        WAIT: begin
          if (rsp) begin
            if (drop)            state_next = REQ;
            else if (path_clear) state_next = accept ? WAIT : REQ;
            else                 state_next = SKID;
          end
        end
        SKID: if (!stall) state_next = REQ;
        default: state_next = REQ;
      endcase
    end
  end

  always_comb begin
    imem_req = 1'b0;
    unique case (state)
      REQ:     imem_req = path_clear && !redirect;
      WAIT:    imem_req = load_mem;
      default: imem_req = 1'b0;
    endcase
  end

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      req_pc     <= '0;
      drop       <= 1'b0;
      id_valid   <= 1'b0;
      id_instr   <= '0;
      id_pc      <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (redirect) begin
      pc         <= redirect_pc & ~ADDR_W'(3);
      drop       <= (state == WAIT) && !imem_rvalid;
      id_valid   <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      if (accept) begin
        pc     <= pc + ADDR_W'(4);
        req_pc <= pc;
      end
      if (rsp && drop) drop <= 1'b0;
      if (load_mem) begin
        id_valid <= 1'b1;
        id_instr <= imem_rdata;
        id_pc    <= req_pc;
      end else if (load_skid) begin
        id_valid <= 1'b1;
        id_instr <= skid_instr;
        id_pc    <= skid_pc;
      end else if (!stall) begin
        id_valid <= 1'b0;
      end
      if (park) begin
        skid_instr <= imem_rdata;
        skid_pc    <= req_pc;
      end
    end
  end

  assign id_pc_plus4  = id_pc + ADDR_W'(4);
  assign id_opcode    = id_instr[6:4];
  assign id_dir_mode  = id_instr[3:2];
  assign id_inst_type = id_instr[1:0];

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (load_mem || load_skid) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (id_valid && stall)     perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: a random-latency memory, an expected in-order instruction stream
// restarted on every redirect, and a monitor that checks each presented IF/ID word against the stream head.
module tb_instr_fetch_stage;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [2:0]  id_opcode;
  logic [1:0]  id_dir_mode;
  logic [1:0]  id_inst_type;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  instr_fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_pc_plus4  (id_pc_plus4),
    .id_opcode    (id_opcode),
    .id_dir_mode  (id_dir_mode),
    .id_inst_type (id_inst_type)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_consumed = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Memory image: address 0 holds an ADDI-style word, everything else a scrambled function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Expected program-order stream of fetch addresses seen at IF/ID.
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    gen_pc = {start[31:2], 2'b00};
    top_up();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    top_up();
  endtask

  task automatic apply_stimulus(input logic s, input logic r, input logic [31:0] rpc);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    if (r) restart_stream(rpc);
  endtask

  // Memory model knobs.
  int mem_ready_pct = 100;
  int mem_fixed_lat = 0;
  int mem_max_lat   = 0;
  int mem_budget    = 1 << 30;

  bit          pending;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          accepted;

  initial begin
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    pending     = 1'b0;
    accepted    = 0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (rst) pending = 1'b0;
      else if (pending) begin
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
        end else begin
          pend_cnt--;
        end
      end
      imem_ready = (accepted < mem_budget) && ($urandom_range(99) < mem_ready_pct);
      @(negedge clk);
      if (imem_rvalid) pending = 1'b0;
      if (!rst && imem_req && imem_ready) begin
        check_output("single_outstanding", {31'b0, pending}, 32'h0);
        check_output("addr_aligned", {30'b0, imem_addr[1:0]}, 32'h0);
        pending   = 1'b1;
        pend_addr = imem_addr;
        pend_cnt  = (mem_fixed_lat >= 0) ? mem_fixed_lat : int'($urandom_range(mem_max_lat));
        accepted++;
      end
    end
  end

  logic [31:0] mon_e;
  logic [31:0] mon_w;

  // Monitor: every cycle IF/ID is live, it must show the head of the expected stream; it pops when decode consumes.
  always @(negedge clk) begin
    if (!rst && id_valid && !redirect) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL scoreboard_empty: got id_pc %h, expected nothing", id_pc);
      end else begin
        mon_e = exp_q[0];
        mon_w = mem_word(mon_e);
        check_output("id_pc", id_pc, mon_e);
        check_output("id_instr", id_instr, mon_w);
        check_output("id_pc_plus4", id_pc_plus4, mon_e + 32'd4);
        check_output("id_opcode", {29'b0, id_opcode}, {29'b0, mon_w[6:4]});
        check_output("id_dir_mode", {30'b0, id_dir_mode}, {30'b0, mon_w[3:2]});
        check_output("id_inst_type", {30'b0, id_inst_type}, {30'b0, mon_w[1:0]});
        if (!stall) begin
          void'(exp_q.pop_front());
          n_consumed++;
        end
      end
    end
  end

  bit          found;
  logic [31:0] target;

  initial begin
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 32'h0);
    restart_stream(RESET_PC);
    mem_budget = 10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_id_valid", {31'b0, id_valid}, 32'h0);
    check_output("reset_id_instr", id_instr, 32'h0);
    check_output("reset_id_pc", id_pc, 32'h0);
    check_output("reset_id_pc_plus4", id_pc_plus4, 32'h4);
    check_output("reset_fields", {25'b0, id_opcode, id_dir_mode, id_inst_type}, 32'h0);

    // Zero-wait memory straight out of reset.
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_output("first_req", {31'b0, imem_req}, 32'h1);
    check_output("first_addr", imem_addr, RESET_PC);
    tick();
    @(negedge clk);
    check_output("second_addr", imem_addr, RESET_PC + 32'd4);
    check_output("id_valid_latency_b", {31'b0, id_valid}, 32'h0);
    tick();
    @(negedge clk);
    check_output("id_valid_latency_c", {31'b0, id_valid}, 32'h1);

    // Stall for three cycles while a response returns: word parks in the skid buffer.
    tick();
    tick();
    apply_stimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check_output("stall_req_off_0", {31'b0, imem_req}, 32'h0);
    tick();
    @(negedge clk);
    check_output("skid_req_off_1", {31'b0, imem_req}, 32'h0);
    tick();
    @(negedge clk);
    check_output("skid_req_off_2", {31'b0, imem_req}, 32'h0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0);
    repeat (20) tick();

    // Memory budget exhausted: request held with a stable address while not accepted.
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check_output("hold_req", {31'b0, imem_req}, 32'h1);
      check_output("hold_addr", imem_addr, 32'h0000_0028);
    end
    check_output("drained_id_valid", {31'b0, id_valid}, 32'h0);
    check_output("consumed_count", n_consumed, 32'd10);
`ifdef FETCH_PERF_CNT_EN
    check_output("perf_fetch_cnt", perf_fetch_cnt, 32'd10);
    check_output("perf_stall_cnt", perf_stall_cnt, 32'd3);
`endif

    // Redirect while a request is outstanding: the response is dropped and the target is fetched next.
    mem_budget    = 1 << 30;
    mem_fixed_lat = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      @(negedge clk);
      if (imem_req && imem_ready) found = 1'b1;
    end
    check_output("wait_accept_timeout", {31'b0, found}, 32'h1);
    tick();
    apply_stimulus(1'b0, 1'b1, 32'h0000_0103);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("redir_id_valid", {31'b0, id_valid}, 32'h0);
    check_output("redir_wait_req", {31'b0, imem_req}, 32'h0);
    tick();
    @(negedge clk);
    check_output("redir_drop_req", {31'b0, imem_req}, 32'h0);
    tick();
    mem_fixed_lat = 0;
    @(negedge clk);
    check_output("redir_target_req", {31'b0, imem_req}, 32'h1);
    check_output("redir_target_addr", imem_addr, 32'h0000_0100);
    repeat (6) tick();

    // Redirect together with stall while IF/ID is full: redirect wins.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      apply_stimulus(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      if (id_valid) found = 1'b1;
    end
    check_output("wait_full_timeout", {31'b0, found}, 32'h1);
    tick();
    apply_stimulus(1'b1, 1'b1, 32'h0000_0400);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("redir_stall_id_valid", {31'b0, id_valid}, 32'h0);
    repeat (8) tick();

    // PC wrap at the top of the address space.
    apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFFE);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0);
    repeat (10) tick();

    // Randomized traffic.
    mem_fixed_lat = -1;
    mem_max_lat   = 3;
    mem_ready_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      tick();
      target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : 32'($urandom);
      apply_stimulus($urandom_range(99) < 30, $urandom_range(99) < 3, target);
    end
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0);
    mem_ready_pct = 100;
    repeat (30) tick();
    check_output("stream_progress", {31'b0, (n_consumed > 300)}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
